apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer.sv | 125 ++++++++++++
 tb/tb_apb_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// APB down-counting timer with prescaler, one-shot/auto-reload modes and a level IRQ.
// Define APB_TIMER_WAIT_EN to add one wait state to every APB access.
module apb_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);

  logic                  en, auto_rl, irq_en;
  logic [31:0]           load_q, count_q;
  logic                  expired;
  logic [PRESCALE_W-1:0] presc_q, presc_cnt, presc_next;
  logic [31:0]           load_next, rdata;
  logic                  access, addr_bad, err, wr_commit, tick;
  logic                  wr_ctrl, wr_load, wr_status, wr_presc;
  logic                  unused_addr_lsbs;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return res;
  endfunction

  assign unused_addr_lsbs = ^PADDR[1:0];
  assign access = PSEL & PENABLE;

`ifdef APB_TIMER_WAIT_EN
  logic wait_q;

  // Set in the first ACCESS cycle, so PREADY rises in the second one.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_q <= 1'b0;
    else          wait_q <= access & ~wait_q;
  end

  assign PREADY = wait_q;
`else
  assign PREADY = 1'b1;
`endif

  assign addr_bad  = PADDR[31:2] > 30'd4;
  assign err       = addr_bad | (PWRITE & (PADDR[4:2] == 3'd2));
  assign PSLVERR   = PRESETn & access & PREADY & err;
  assign wr_commit = PRESETn & access & PWRITE & PREADY & ~err;

  assign wr_ctrl   = wr_commit & (PADDR[4:2] == 3'd0);
  assign wr_load   = wr_commit & (PADDR[4:2] == 3'd1);
  assign wr_status = wr_commit & (PADDR[4:2] == 3'd3);
  assign wr_presc  = wr_commit & (PADDR[4:2] == 3'd4);

  assign tick      = en & (presc_cnt == presc_q);
  assign load_next = merge_bytes(load_q, PWDATA, PSTRB);

  always_comb begin
    presc_next = presc_q;
    for (int i = 0; i < PRESCALE_W; i++)
      if (PSTRB[i/8]) presc_next[i] = PWDATA[i];
  end

  always_comb begin
    rdata = '0;
    case (PADDR[4:2])
      3'd0:    rdata = {29'd0, irq_en, auto_rl, en};
      3'd1:    rdata = load_q;
      3'd2:    rdata = count_q;
      3'd3:    rdata = {31'd0, expired};
      3'd4:    rdata = {{(32-PRESCALE_W){1'b0}}, presc_q};
      default: rdata = '0;
    endcase
  end

  assign PRDATA = (PRESETn && access && !PWRITE && !addr_bad) ? rdata : '0;
  assign IRQ    = expired & irq_en;

  // Later assignments win, which encodes the collision precedence:
  // HW EN clear over CTRL write, EXP set over W1C, LOAD write over tick.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      irq_en    <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      expired   <= 1'b0;
      presc_q   <= '0;
      presc_cnt <= '0;
    end else begin
      if (wr_ctrl && PSTRB[0]) {irq_en, auto_rl, en} <= PWDATA[2:0];
      if (tick && count_q == 32'd0 && !auto_rl) en <= 1'b0;

      if (wr_presc) presc_q <= presc_next;

      if (wr_status && PSTRB[0] && PWDATA[0]) expired <= 1'b0;
      if (tick && count_q == 32'd0) expired <= 1'b1;

      if (tick) begin
        if (count_q != 32'd0) count_q <= count_q - 32'd1;
        else if (auto_rl)     count_q <= load_q;
      end

      if (en) presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);

      if (wr_load) begin
        load_q    <= load_next;
        count_q   <= load_next;
        presc_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: stimulus queues expected responses, a monitor
// compares them whenever an APB access completes.
module tb_apb_timer;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, IRQ;

  always #5 PCLK = ~PCLK;

  apb_timer #(.PRESCALE_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .IRQ(IRQ)
  );

`ifdef APB_TIMER_WAIT_EN
  localparam int ACCESS_CYCLES = 2;
  localparam logic RESET_READY = 1'b0;
`else
  localparam int ACCESS_CYCLES = 1;
  localparam logic RESET_READY = 1'b1;
`endif

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int oneshot_cnt[5]  = '{2, 1, 0, 0, 0};
  int oneshot_irq[5]  = '{0, 0, 0, 1, 1};
  int autorl_cnt[12]  = '{2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] rdata, input logic err, input logic irq);
    sb.push_back('{name, rdata, err, irq});
  endtask

  // Monitor: every completed access pops one expected response.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESETn && PSEL && PENABLE && PREADY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected access: got addr 0x%08h expected no access", PADDR);
      end else begin
        e = sb.pop_front();
        check_output({e.name, " rdata"}, PRDATA, e.rdata);
        check_output({e.name, " pslverr"}, 32'(PSLVERR), 32'(e.err));
        check_output({e.name, " irq"}, 32'(IRQ), 32'(e.irq));
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input string name,
                          input logic [31:0] rdata, input logic err, input logic irq);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    push_exp(name, rdata, err, irq);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 8);
    check_output({name, " access cycles"}, n, ACCESS_CYCLES);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input string name, input logic err, input logic irq);
    apb_xfer(1'b1, addr, data, strb, name, 32'd0, err, irq);
  endtask

  task automatic apb_read(input logic [31:0] addr, input string name,
                          input logic [31:0] rdata, input logic err, input logic irq);
    apb_xfer(1'b0, addr, 32'd0, 4'h0, name, rdata, err, irq);
  endtask

  // Holds one read access open for n cycles so COUNT is observed every cycle.
  task automatic cont_read(input logic [31:0] addr, input int n);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PSTRB = 4'h0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (n) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    PRESETn = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h14; PWDATA = '0; PSTRB = '0;
    #12;
    check_output("reset pready", 32'(PREADY), 32'(RESET_READY));
    check_output("reset prdata", PRDATA, 32'd0);
    check_output("reset pslverr", 32'(PSLVERR), 32'd0);
    check_output("reset irq", 32'(IRQ), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    apb_write(32'h04, 32'h5, 4'hF, "wr LOAD", 1'b0, 1'b0);
    apb_read (32'h04, "rd LOAD", 32'h5, 1'b0, 1'b0);
    apb_read (32'h08, "rd COUNT", 32'h5, 1'b0, 1'b0);

    apb_write(32'h08, 32'h99, 4'hF, "wr COUNT err", 1'b1, 1'b0);
    apb_read (32'h08, "rd COUNT after err", 32'h5, 1'b0, 1'b0);
    apb_read (32'h14, "rd 0x14 err", 32'h0, 1'b1, 1'b0);
    apb_write(32'h14, 32'h7, 4'hF, "wr 0x14 err", 1'b1, 1'b0);

    // One-shot: ticks every cycle, expires one cycle after COUNT reaches 0.
    apb_write(32'h10, 32'h0, 4'hF, "wr PRESC 0", 1'b0, 1'b0);
    apb_write(32'h04, 32'h3, 4'hF, "wr LOAD 3", 1'b0, 1'b0);
    apb_write(32'h00, 32'h5, 4'hF, "wr CTRL 5", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      push_exp($sformatf("oneshot count %0d", i), 32'(oneshot_cnt[i]), 1'b0, oneshot_irq[i][0]);
    cont_read(32'h08, 5);
    apb_read (32'h00, "rd CTRL en cleared", 32'h4, 1'b0, 1'b1);
    apb_read (32'h0C, "rd STATUS exp", 32'h1, 1'b0, 1'b1);
    apb_write(32'h0C, 32'h1, 4'hF, "w1c STATUS", 1'b0, 1'b1);
    apb_read (32'h0C, "rd STATUS cleared", 32'h0, 1'b0, 1'b0);

    // W1C lands on the same edge that EXP sets.
    apb_write(32'h04, 32'h2, 4'hF, "wr LOAD 2", 1'b0, 1'b0);
    apb_write(32'h00, 32'h5, 4'hF, "wr CTRL 5 again", 1'b0, 1'b0);
    apb_write(32'h0C, 32'h1, 4'hF, "w1c collide", 1'b0, 1'b0);
    apb_read (32'h0C, "rd STATUS after collide", 32'h1, 1'b0, 1'b1);
    apb_read (32'h08, "rd COUNT after collide", 32'h0, 1'b0, 1'b1);
    apb_read (32'h00, "rd CTRL after collide", 32'h4, 1'b0, 1'b1);
    apb_write(32'h0C, 32'h1, 4'hF, "w1c later", 1'b0, 1'b1);
    apb_read (32'h0C, "rd STATUS after w1c", 32'h0, 1'b0, 1'b0);

    // Auto-reload: PRESC=1 ticks every 2 cycles, 3 ticks per expiry.
    apb_write(32'h10, 32'h1, 4'hF, "wr PRESC 1", 1'b0, 1'b0);
    apb_write(32'h04, 32'h2, 4'hF, "wr LOAD 2 auto", 1'b0, 1'b0);
    apb_write(32'h00, 32'h3, 4'hF, "wr CTRL 3", 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      push_exp($sformatf("auto count %0d", i), 32'(autorl_cnt[i]), 1'b0, 1'b0);
    cont_read(32'h08, 12);
    apb_read (32'h0C, "rd STATUS auto", 32'h1, 1'b0, 1'b0);
    apb_read (32'h00, "rd CTRL auto", 32'h3, 1'b0, 1'b0);
    apb_write(32'h00, 32'h0, 4'hF, "wr CTRL stop", 1'b0, 1'b0);
    apb_write(32'h0C, 32'h1, 4'hF, "w1c auto", 1'b0, 1'b0);
    apb_read (32'h0C, "rd STATUS auto cleared", 32'h0, 1'b0, 1'b0);

    // Byte strobes and register widths.
    apb_write(32'h04, 32'hAABBCCDD, 4'hF, "wr LOAD full", 1'b0, 1'b0);
    apb_write(32'h04, 32'h11223344, 4'b0101, "wr LOAD strobed", 1'b0, 1'b0);
    apb_read (32'h04, "rd LOAD strobed", 32'hAA22CC44, 1'b0, 1'b0);
    apb_read (32'h08, "rd COUNT strobed", 32'hAA22CC44, 1'b0, 1'b0);
    apb_write(32'h10, 32'hFFFFFFFF, 4'hF, "wr PRESC all ones", 1'b0, 1'b0);
    apb_read (32'h10, "rd PRESC width", 32'h0000FFFF, 1'b0, 1'b0);
    apb_write(32'h00, 32'hFFFFFFFE, 4'hF, "wr CTRL ones", 1'b0, 1'b0);
    apb_read (32'h00, "rd CTRL bits", 32'h6, 1'b0, 1'b0);
    apb_write(32'h00, 32'h0, 4'h0, "wr CTRL no strobe", 1'b0, 1'b0);
    apb_read (32'h00, "rd CTRL unchanged", 32'h6, 1'b0, 1'b0);

    // Reset pulsed during the ACCESS phase of a LOAD write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h12345678; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check_output("midreset pready", 32'(PREADY), 32'(RESET_READY));
    check_output("midreset pslverr", 32'(PSLVERR), 32'd0);
    check_output("midreset irq", 32'(IRQ), 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b1;
    apb_read (32'h00, "post reset CTRL", 32'h0, 1'b0, 1'b0);
    apb_read (32'h04, "post reset LOAD", 32'h0, 1'b0, 1'b0);
    apb_read (32'h08, "post reset COUNT", 32'h0, 1'b0, 1'b0);
    apb_read (32'h0C, "post reset STATUS", 32'h0, 1'b0, 1'b0);
    apb_read (32'h10, "post reset PRESC", 32'h0, 1'b0, 1'b0);

    repeat (3) @(posedge PCLK);
    check_output("scoreboard drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
